// File: rtl/ram_stream_reader.sv
// Streaming read master for a single-clock RAM with one-cycle registered read latency.
// Issues reads under credit control into a 4-entry FIFO that feeds a valid/ready stream.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 1024,
  localparam int ADDRESS_WIDTH = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     r_enable,
  output logic [ADDRESS_WIDTH-1:0] r_address,
  input  logic [DATA_WIDTH-1:0]    r_data,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [1:0]               fsm_state
);

  // Stream handshake: a word transfers on every edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that word is taken.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = ADDRESS_WIDTH'(SIZE - 1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH + 1)'(1);

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_cnt;
  logic [ADDRESS_WIDTH:0]   issue_cnt;
  logic [ADDRESS_WIDTH:0]   pop_cnt;
  logic                     s1;
  logic [DATA_WIDTH-1:0]    fifo_mem [4];
  logic [1:0]               wr_ptr, rd_ptr;
  logic [2:0]               fifo_count;
  logic                     accept, push, pop;
  logic [3:0]               credit_used;

  // With one-cycle RAM latency the word issued last cycle is on r_data now and is
  // pushed at this edge, so s1 alone covers everything in flight.
  assign push        = s1;
  assign pop         = out_valid && out_ready;
  assign out_valid   = (fifo_count != 3'd0);
  assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
  assign credit_used = {1'b0, fifo_count} + {3'b000, s1} - {3'b000, pop};
  assign r_address   = addr_cnt;
  assign fsm_state   = state;
  // The done cycle counts as idle so a back-to-back start is not lost.
  assign accept      = start && ((state == IDLE) || done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A zero-length start goes straight to FLUSH with nothing to pop, so done
  // fires the following cycle without busy ever rising.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (length != '0) ? RUN : FLUSH;
      RUN:     if (issue_cnt == '0) state_next = FLUSH;
      FLUSH: begin
        if (pop_cnt == '0) begin
          if (start) state_next = (length != '0) ? RUN : FLUSH;
          else       state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done     = (state == FLUSH) && (pop_cnt == '0);
    busy     = (state != IDLE) && !done;
    r_enable = (state == RUN) && (issue_cnt != '0) && (credit_used < 4'd4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      s1        <= 1'b0;
    end else begin
      s1 <= r_enable;
      if (accept) begin
        addr_cnt  <= start_address;
        issue_cnt <= length;
        pop_cnt   <= length;
      end else begin
        if (r_enable) begin
          addr_cnt  <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_ONE;
          issue_cnt <= issue_cnt - CNT_ONE;
        end
        if (pop) pop_cnt <= pop_cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= r_data;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
